// File: rtl/cdb_broadcaster_if.sv
// Handshake bundle between the three execution units and the CDB broadcaster.
// Producers drive valid/data/inst; the broadcaster drives ready, the cdb_* outputs and busy.
interface cdb_broadcaster_if #(
  parameter int DATA_W = 16
);
  logic              add_valid;
  logic              add_ready;
  logic [DATA_W-1:0] add_data;
  logic [DATA_W-1:0] add_inst;
  logic              mul_valid;
  logic              mul_ready;
  logic [DATA_W-1:0] mul_data;
  logic [DATA_W-1:0] mul_inst;
  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_inst;
  logic              cdb_done;
  logic [DATA_W-1:0] cdb_data;
  logic [DATA_W-1:0] cdb_inst;
  logic [2:0]        cdb_tag;
  logic              cdb_regwr;
  logic              cdb_is_store;
  logic [1:0]        cdb_src;
  logic              busy;

  modport master (
    output add_valid, add_data, add_inst,
    output mul_valid, mul_data, mul_inst,
    output mem_valid, mem_data, mem_inst,
    input  add_ready, mul_ready, mem_ready,
    input  cdb_done, cdb_data, cdb_inst, cdb_tag, cdb_regwr, cdb_is_store, cdb_src, busy
  );

  modport slave (
    input  add_valid, add_data, add_inst,
    input  mul_valid, mul_data, mul_inst,
    input  mem_valid, mem_data, mem_inst,
    output add_ready, mul_ready, mem_ready,
    output cdb_done, cdb_data, cdb_inst, cdb_tag, cdb_regwr, cdb_is_store, cdb_src, busy
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// Round-robin CDB broadcaster: one-entry slot per source, pulse on cdb_done one cycle after the grant edge.
// Backpressure: a source's ready is low while its slot is full; it returns the cycle after that slot is granted.
module cdb_broadcaster #(
  parameter int DATA_W = 16,
  parameter int GAP    = 1
) (
  input logic              clock,
  input logic              reset,
  cdb_broadcaster_if.slave bus
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic {IDLE, BCAST} stateT;

  stateT             state;
  stateT             stateNext;
  logic [GW-1:0]     gapCnt;
  logic [1:0]        rrPtr;
  logic [2:0]        slotFull;
  logic [DATA_W-1:0] slotData [3];
  logic [DATA_W-1:0] slotInst [3];
  logic [2:0]        inVld;
  logic [DATA_W-1:0] inData [3];
  logic [DATA_W-1:0] inInst [3];
  logic              pickVld;
  logic [1:0]        pickIdx;
  logic [1:0]        candIdx;
  logic              grant;
  logic [4:0]        grantDec;

  logic              cdbDone;
  logic [DATA_W-1:0] cdbData;
  logic [DATA_W-1:0] cdbInst;
  logic [2:0]        cdbTag;
  logic              cdbRegwr;
  logic              cdbIsStore;
  logic [1:0]        cdbSrc;

  // Returns {isStore, regwr, tag} for an instruction word.
  function automatic logic [4:0] decodeInst(input logic [DATA_W-1:0] inst);
    case (inst[3:0])
      4'b0000, 4'b0001, 4'b0100: decodeInst = {2'b01, inst[12:10]};
      4'b0010:                   decodeInst = {2'b01, inst[6:4]};
      4'b0011:                   decodeInst = 5'b10000;
      default:                   decodeInst = 5'b00000;
    endcase
  endfunction

  assign inVld     = {bus.mem_valid, bus.mul_valid, bus.add_valid};
  assign inData[0] = bus.add_data;
  assign inData[1] = bus.mul_data;
  assign inData[2] = bus.mem_data;
  assign inInst[0] = bus.add_inst;
  assign inInst[1] = bus.mul_inst;
  assign inInst[2] = bus.mem_inst;

  // Search starts one past the last winner so it ranks lowest this round.
  always_comb begin
    pickVld = 1'b0;
    pickIdx = 2'd0;
    candIdx = rrPtr;
    for (int k = 0; k < 3; k++) begin
      candIdx = (candIdx == 2'd2) ? 2'd0 : candIdx + 2'd1;
      if (!pickVld && slotFull[candIdx]) begin
        pickVld = 1'b1;
        pickIdx = candIdx;
      end
    end
  end

  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (pickVld && gapCnt == '0) begin
          grant     = 1'b1;
          stateNext = BCAST;
        end
      end
      BCAST:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign grantDec = decodeInst(slotInst[pickIdx]);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slotFull   <= 3'b000;
      gapCnt     <= '0;
      rrPtr      <= 2'd2;
      cdbDone    <= 1'b0;
      cdbData    <= '0;
      cdbInst    <= '0;
      cdbTag     <= 3'd0;
      cdbRegwr   <= 1'b0;
      cdbIsStore <= 1'b0;
      cdbSrc     <= 2'd0;
    end else begin
      // Accepts only hit empty slots and grants only full ones, so they never collide.
      for (int s = 0; s < 3; s++) begin
        if (inVld[s] && !slotFull[s]) begin
          slotFull[s] <= 1'b1;
          slotData[s] <= inData[s];
          slotInst[s] <= inInst[s];
        end
      end
      if (grant) begin
        slotFull[pickIdx] <= 1'b0;
        rrPtr             <= pickIdx;
        cdbDone           <= 1'b1;
        cdbData           <= slotData[pickIdx];
        cdbInst           <= slotInst[pickIdx];
        cdbTag            <= grantDec[2:0];
        cdbRegwr          <= grantDec[3];
        cdbIsStore        <= grantDec[4];
        cdbSrc            <= pickIdx;
      end else if (state == BCAST) begin
        cdbDone <= 1'b0;
        gapCnt  <= GW'(GAP - 1);
      end else if (gapCnt != '0) begin
        gapCnt <= gapCnt - 1'b1;
      end
    end
  end

  assign bus.add_ready    = !slotFull[0];
  assign bus.mul_ready    = !slotFull[1];
  assign bus.mem_ready    = !slotFull[2];
  assign bus.cdb_done     = cdbDone;
  assign bus.cdb_data     = cdbData;
  assign bus.cdb_inst     = cdbInst;
  assign bus.cdb_tag      = cdbTag;
  assign bus.cdb_regwr    = cdbRegwr;
  assign bus.cdb_is_store = cdbIsStore;
  assign bus.cdb_src      = cdbSrc;
  assign bus.busy         = (|slotFull) || (state != IDLE);
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: two instances (GAP=1 and GAP=3) checked every cycle against a
// transaction-level model, plus directed scenarios for latency, ordering, decode, gap and reset.
module tb_cdb_broadcaster;
  localparam int DW    = 16;
  localparam int GAP_A = 1;
  localparam int GAP_B = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdb_broadcaster_if #(.DATA_W(DW)) busA ();
  cdb_broadcaster_if #(.DATA_W(DW)) busB ();

  cdb_broadcaster #(.DATA_W(DW), .GAP(GAP_A)) dutA (.clock(clock), .reset(reset), .bus(busA));
  cdb_broadcaster #(.DATA_W(DW), .GAP(GAP_B)) dutB (.clock(clock), .reset(reset), .bus(busB));

  // Stimulus arrays [instance][source], source 0 add, 1 mul, 2 mem.
  logic          vld [2][3];
  logic [DW-1:0] dat [2][3];
  logic [DW-1:0] ins [2][3];

  assign busA.add_valid = vld[0][0];  assign busA.add_data = dat[0][0];  assign busA.add_inst = ins[0][0];
  assign busA.mul_valid = vld[0][1];  assign busA.mul_data = dat[0][1];  assign busA.mul_inst = ins[0][1];
  assign busA.mem_valid = vld[0][2];  assign busA.mem_data = dat[0][2];  assign busA.mem_inst = ins[0][2];
  assign busB.add_valid = vld[1][0];  assign busB.add_data = dat[1][0];  assign busB.add_inst = ins[1][0];
  assign busB.mul_valid = vld[1][1];  assign busB.mul_data = dat[1][1];  assign busB.mul_inst = ins[1][1];
  assign busB.mem_valid = vld[1][2];  assign busB.mem_data = dat[1][2];  assign busB.mem_inst = ins[1][2];

  logic          gRdy [2][3];
  logic          gDone [2];
  logic          gBusy [2];
  logic          gRegwr [2];
  logic          gStore [2];
  logic [DW-1:0] gData [2];
  logic [DW-1:0] gInst [2];
  logic [2:0]    gTag [2];
  logic [1:0]    gSrc [2];

  assign gRdy[0][0] = busA.add_ready;  assign gRdy[0][1] = busA.mul_ready;  assign gRdy[0][2] = busA.mem_ready;
  assign gRdy[1][0] = busB.add_ready;  assign gRdy[1][1] = busB.mul_ready;  assign gRdy[1][2] = busB.mem_ready;
  assign gDone[0] = busA.cdb_done;      assign gDone[1] = busB.cdb_done;
  assign gBusy[0] = busA.busy;          assign gBusy[1] = busB.busy;
  assign gRegwr[0] = busA.cdb_regwr;    assign gRegwr[1] = busB.cdb_regwr;
  assign gStore[0] = busA.cdb_is_store; assign gStore[1] = busB.cdb_is_store;
  assign gData[0] = busA.cdb_data;      assign gData[1] = busB.cdb_data;
  assign gInst[0] = busA.cdb_inst;      assign gInst[1] = busB.cdb_inst;
  assign gTag[0] = busA.cdb_tag;        assign gTag[1] = busB.cdb_tag;
  assign gSrc[0] = busA.cdb_src;        assign gSrc[1] = busB.cdb_src;

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int gapOf(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  // Expected {isStore, regwr, tag} straight from the opcode table.
  function automatic logic [4:0] expDecode(input logic [DW-1:0] inst);
    logic [3:0] op;
    op = inst[3:0];
    if (op inside {4'h0, 4'h1, 4'h4}) return {2'b01, inst[12:10]};
    if (op == 4'h2) return {2'b01, inst[6:4]};
    if (op == 4'h3) return 5'b10000;
    return 5'b00000;
  endfunction

  // Model: pending item per source, index of the last winner, and the earliest edge a grant may occur.
  bit            mPend [2][3];
  logic [DW-1:0] mData [2][3];
  logic [DW-1:0] mInst [2][3];
  int            lastSrc [2];
  int            nextOk [2];
  bit            eDone [2];
  bit            eBusy [2];
  bit            eRegwr [2];
  bit            eStore [2];
  logic [DW-1:0] eData [2];
  logic [DW-1:0] eInst [2];
  logic [2:0]    eTag [2];
  logic [1:0]    eSrc [2];
  int            edgeN = 0;
  int            g;
  int            cand;
  bit            pb [3];
  bit            modelOn = 1'b0;

  always @(posedge clock) begin
    edgeN++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int s = 0; s < 3; s++) mPend[i][s] = 1'b0;
        eDone[i] = 0; eRegwr[i] = 0; eStore[i] = 0;
        eData[i] = '0; eInst[i] = '0; eTag[i] = '0; eSrc[i] = '0;
        lastSrc[i] = 2;
        nextOk[i] = 0;
      end else begin
        for (int s = 0; s < 3; s++) pb[s] = mPend[i][s];
        g = -1;
        if (edgeN >= nextOk[i]) begin
          for (int k = 1; k <= 3; k++) begin
            cand = (lastSrc[i] + k) % 3;
            if (g < 0 && pb[cand]) g = cand;
          end
        end
        eDone[i] = (g >= 0);
        if (g >= 0) begin
          eData[i] = mData[i][g];
          eInst[i] = mInst[i][g];
          {eStore[i], eRegwr[i], eTag[i]} = expDecode(mInst[i][g]);
          eSrc[i] = 2'(g);
          lastSrc[i] = g;
          nextOk[i] = edgeN + 1 + gapOf(i);
          mPend[i][g] = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
          if (vld[i][s] && !pb[s]) begin
            mPend[i][s] = 1'b1;
            mData[i][s] = dat[i][s];
            mInst[i][s] = ins[i][s];
          end
        end
      end
      eBusy[i] = eDone[i] || mPend[i][0] || mPend[i][1] || mPend[i][2];
    end
  end

  always @(negedge clock) begin
    if (modelOn) begin
      for (int i = 0; i < 2; i++) begin
        for (int s = 0; s < 3; s++)
          chk($sformatf("u%0d ready%0d", i, s), 32'(gRdy[i][s]), 32'(!mPend[i][s]));
        chk($sformatf("u%0d done", i), 32'(gDone[i]), 32'(eDone[i]));
        chk($sformatf("u%0d busy", i), 32'(gBusy[i]), 32'(eBusy[i]));
        chk($sformatf("u%0d data", i), 32'(gData[i]), 32'(eData[i]));
        chk($sformatf("u%0d inst", i), 32'(gInst[i]), 32'(eInst[i]));
        chk($sformatf("u%0d tag", i), 32'(gTag[i]), 32'(eTag[i]));
        chk($sformatf("u%0d regwr", i), 32'(gRegwr[i]), 32'(eRegwr[i]));
        chk($sformatf("u%0d store", i), 32'(gStore[i]), 32'(eStore[i]));
        chk($sformatf("u%0d src", i), 32'(gSrc[i]), 32'(eSrc[i]));
      end
    end
  end

  task automatic clearInputs();
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 3; s++) begin
        vld[i][s] = 1'b0; dat[i][s] = '0; ins[i][s] = '0;
      end
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic offer(input int i, input int s, input logic [DW-1:0] d, input logic [DW-1:0] n);
    vld[i][s] = 1'b1; dat[i][s] = d; ins[i][s] = n;
  endtask

  // Advances negedge by negedge until cdb_done is seen high, at most 'budget' cycles.
  task automatic waitPulse(input int i, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clock);
      seen = gDone[i];
    end
    chk({tag, " pulse seen"}, 32'(seen), 32'd1);
  endtask

  int lowCnt;

  initial begin
    reset = 1'b1;
    clearInputs();
    repeat (2) @(negedge clock);
    modelOn = 1'b1;
    chk("reset done", 32'(gDone[0]), 32'd0);
    chk("reset data", 32'(gData[0]), 32'd0);
    chk("reset busy", 32'(gBusy[0]), 32'd0);
    for (int s = 0; s < 3; s++) chk($sformatf("reset ready%0d", s), 32'(gRdy[0][s]), 32'd1);
    reset = 1'b0;

    // Single add: pulse in the cycle after the edge following acceptance.
    @(negedge clock);
    offer(0, 0, 16'h1234, 16'h0C00);
    @(negedge clock);
    vld[0][0] = 1'b0;
    chk("add not yet", 32'(gDone[0]), 32'd0);
    chk("add ready low", 32'(gRdy[0][0]), 32'd0);
    @(negedge clock);
    chk("add done", 32'(gDone[0]), 32'd1);
    chk("add tag", 32'(gTag[0]), 32'd3);
    chk("add regwr", 32'(gRegwr[0]), 32'd1);
    chk("add data", 32'(gData[0]), 32'h1234);
    chk("add src", 32'(gSrc[0]), 32'd0);
    @(negedge clock);
    chk("add done drop", 32'(gDone[0]), 32'd0);
    chk("add idle", 32'(gBusy[0]), 32'd0);

    // All three at once: add, mul, mem order with one low cycle between pulses.
    doReset();
    offer(0, 0, 16'h1111, 16'h0C00);
    offer(0, 1, 16'h2222, 16'h1404);
    offer(0, 2, 16'h3333, 16'h0052);
    @(negedge clock);
    clearInputs();
    chk("trio first", 32'(gDone[0]), 32'd0);
    for (int p = 0; p < 6; p++) begin
      @(negedge clock);
      chk($sformatf("trio done%0d", p), 32'(gDone[0]), 32'(p % 2 == 0));
      if (p % 2 == 0) chk($sformatf("trio src%0d", p), 32'(gSrc[0]), 32'(p / 2));
      if (p == 4) chk("trio busy last", 32'(gBusy[0]), 32'd1);
    end
    chk("trio busy drop", 32'(gBusy[0]), 32'd0);

    // Load then store through the memory port.
    doReset();
    offer(0, 2, 16'h0040, 16'h0052);
    @(negedge clock);
    clearInputs();
    waitPulse(0, 10, "load");
    chk("load tag", 32'(gTag[0]), 32'd5);
    chk("load regwr", 32'(gRegwr[0]), 32'd1);
    chk("load store", 32'(gStore[0]), 32'd0);
    offer(0, 2, 16'h0020, 16'h0003);
    @(negedge clock);
    clearInputs();
    waitPulse(0, 10, "store");
    chk("store regwr", 32'(gRegwr[0]), 32'd0);
    chk("store flag", 32'(gStore[0]), 32'd1);
    chk("store data", 32'(gData[0]), 32'h0020);

    // Backpressure: last winner is add, so mul and mem are served first while add keeps offering.
    doReset();
    offer(0, 0, 16'h0BAD, 16'h0401);
    @(negedge clock);
    clearInputs();
    waitPulse(0, 10, "bp prime");
    @(negedge clock);
    offer(0, 1, 16'h5151, 16'h0804);
    offer(0, 2, 16'h6262, 16'h0032);
    for (int c = 0; c < 10; c++) begin
      offer(0, 0, 16'hA000 + 16'(c), 16'h1000);
      @(negedge clock);
      vld[0][1] = 1'b0;
      vld[0][2] = 1'b0;
      if (c == 0) chk("bp add held", 32'(gRdy[0][0]), 32'd0);
    end
    clearInputs();
    repeat (8) @(negedge clock);

    // GAP=3 instance: exactly three low cycles between two queued pulses.
    doReset();
    offer(1, 0, 16'h0A0A, 16'h0C00);
    offer(1, 1, 16'h0B0B, 16'h0804);
    @(negedge clock);
    clearInputs();
    waitPulse(1, 10, "gap3 first");
    lowCnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (gDone[1]) break;
      lowCnt++;
    end
    chk("gap3 low cycles", 32'(lowCnt), 32'd3);
    chk("gap3 second src", 32'(gSrc[1]), 32'd1);

    // Reset while broadcasting: pulse ends, queued work is dropped.
    doReset();
    offer(0, 0, 16'h7777, 16'h0C00);
    offer(0, 1, 16'h8888, 16'h1404);
    @(negedge clock);
    clearInputs();
    waitPulse(0, 10, "rst bcast");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst done", 32'(gDone[0]), 32'd0);
    chk("rst busy", 32'(gBusy[0]), 32'd0);
    chk("rst mul ready", 32'(gRdy[0][1]), 32'd1);
    lowCnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (gDone[0]) lowCnt++;
    end
    chk("rst no pulse", 32'(lowCnt), 32'd0);

    // Random traffic on both instances with varying offer density.
    doReset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++)
        for (int s = 0; s < 3; s++) begin
          vld[i][s] = ($urandom_range(0, 9) < (c / 300) * 2 + 1);
          dat[i][s] = 16'($urandom);
          ins[i][s] = {12'($urandom), 4'($urandom_range(0, 7))};
        end
      if (c == 700 || c == 1201) reset = 1'b1;
      else reset = 1'b0;
      @(negedge clock);
    end
    clearInputs();
    reset = 1'b0;
    repeat (12) @(negedge clock);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
